// File: rtl/alien_sprite_drawer.sv
// alien_sprite_drawer
//   Turns changes in the alien's (x, y) position into a stream of VGA-adapter
//   pixel writes. The sprite is first erased at the previously drawn position
//   with BG_COLOUR, then drawn at the new position with ALIEN_COLOUR. One
//   pixel is written per clock, in raster order (x fastest, then y).
//
//   Optional feature (macro SPRITE_ROM_EN):
//     defined   - DRAW consults an internal 8x8 1-bit bitmap at (cy, cx); a 0
//                 bit is transparent (plot stays low that cycle). ERASE still
//                 clears the whole rectangle and cycle counts do not change.
//     undefined - the sprite is a solid SPRITE_W x SPRITE_H rectangle.
//
// Ports:
//   clk     in   1  system clock
//   resetn  in   1  asynchronous active-low reset
//   pos_x   in   8  current alien x (top-left of sprite)
//   pos_y   in   7  current alien y (top-left of sprite)
//   busy    out  1  high while in ERASE, DRAW or DONE
//   done    out  1  one-cycle pulse when a redraw completes
//   plot    out  1  pixel write enable to the VGA adapter
//   vga_x   out  8  pixel x
//   vga_y   out  7  pixel y
//   colour  out  3  pixel colour
//
// Handshake: there is no back-pressure. The mover presents pos_x/pos_y
// continuously; a new position is sampled only while idle, and every cycle
// with plot=1 is a pixel write the adapter must accept. vga_x/vga_y/colour
// are meaningful only when plot=1.
//
// All outputs are registered from the *next* state and counters, so busy,
// done and each pixel line up exactly with the FSM state that produces them.

module alien_sprite_drawer #(
  parameter int          SPRITE_W     = 4,
  parameter int          SPRITE_H     = 4,
  parameter logic [2:0]  ALIEN_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  output logic       busy,
  output logic       done,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CX_LAST = 3'(SPRITE_W - 1);
  localparam logic [2:0] CY_LAST = 3'(SPRITE_H - 1);

`ifdef SPRITE_ROM_EN
  // Row-indexed bitmap; bit [cx] of row [cy] is the pixel at (cx, cy).
  localparam logic [7:0] SPRITE_ROM [0:7] = '{
    8'b00011000,
    8'b00111100,
    8'b01111110,
    8'b11011011,
    8'b11111111,
    8'b00100100,
    8'b01011010,
    8'b10100101
  };
`endif

  state_t     state, state_nx;
  logic [2:0] cx, cx_nx;
  logic [2:0] cy, cy_nx;
  logic [7:0] new_x, new_x_nx;
  logic [6:0] new_y, new_y_nx;
  logic [7:0] old_x;
  logic [6:0] old_y;
  logic       valid;

  logic       start;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic       on_screen;
  logic       rom_bit;
  logic       plot_nx;

  // A redraw is needed on the very first pass, or whenever the mover has
  // reported a position different from the one currently on screen.
  assign start = !valid || (pos_x != old_x) || (pos_y != old_y);

  // Next-state and counter logic.
  always_comb begin
    state_nx = state;
    cx_nx    = cx;
    cy_nx    = cy;
    new_x_nx = new_x;
    new_y_nx = new_y;
    case (state)
      IDLE: begin
        if (start) begin
          new_x_nx = pos_x;
          new_y_nx = pos_y;
          cx_nx    = 3'd0;
          cy_nx    = 3'd0;
          state_nx = valid ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (cx == CX_LAST) begin
          cx_nx = 3'd0;
          if (cy == CY_LAST) begin
            cy_nx    = 3'd0;
            state_nx = (state == ERASE) ? DRAW : DONE;
          end else begin
            cy_nx = cy + 3'd1;
          end
        end else begin
          cx_nx = cx + 3'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pixel address for the cycle being registered. Sums are 9 bits so that
  // positions near the right/bottom edge are clipped rather than wrapped.
  always_comb begin
    base_x    = (state_nx == ERASE) ? old_x : new_x_nx;
    base_y    = (state_nx == ERASE) ? old_y : new_y_nx;
    sum_x     = {1'b0, base_x} + {6'b0, cx_nx};
    sum_y     = {2'b0, base_y} + {6'b0, cy_nx};
    on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
`ifdef SPRITE_ROM_EN
    rom_bit   = SPRITE_ROM[cy_nx][cx_nx];
`else
    rom_bit   = 1'b1;
`endif
    plot_nx   = on_screen &&
                ((state_nx == ERASE) || ((state_nx == DRAW) && rom_bit));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cx     <= 3'd0;
      cy     <= 3'd0;
      new_x  <= 8'd0;
      new_y  <= 7'd0;
      old_x  <= 8'd0;
      old_y  <= 7'd0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      vga_x  <= 8'd0;
      vga_y  <= 7'd0;
      colour <= BG_COLOUR;
    end else begin
      state <= state_nx;
      cx    <= cx_nx;
      cy    <= cy_nx;
      new_x <= new_x_nx;
      new_y <= new_y_nx;
      // Commit the drawn position when leaving DONE so IDLE compares against
      // what is actually on screen.
      if (state == DONE) begin
        old_x <= new_x;
        old_y <= new_y;
        valid <= 1'b1;
      end
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      plot <= plot_nx;
      if ((state_nx == ERASE) || (state_nx == DRAW)) begin
        vga_x  <= sum_x[7:0];
        vga_y  <= sum_y[6:0];
        colour <= (state_nx == ERASE) ? BG_COLOUR : ALIEN_COLOUR;
      end
    end
  end

endmodule

// File: tb/tb_alien_sprite_drawer.sv
// tb_alien_sprite_drawer
//   Bench for alien_sprite_drawer. A transaction-level model turns each
//   position the drawer should pick up into the full list of expected output
//   cycles (erase rectangle, draw rectangle, done pulse, idle gap) and
//   compares it cycle by cycle against the DUT outputs at the falling edge.
//   Honours SPRITE_ROM_EN the same way the design does.

module tb_alien_sprite_drawer;

  localparam int         SW    = 4;
  localparam int         SH    = 4;
  localparam logic [2:0] ALIEN = 3'b010;
  localparam logic [2:0] BG    = 3'b000;
  localparam int         SCR_W = 160;
  localparam int         SCR_H = 120;

`ifdef SPRITE_ROM_EN
  localparam logic [7:0] ROM_TB [0:7] = '{
    8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
    8'b11111111, 8'b00100100, 8'b01011010, 8'b10100101
  };
`endif

  logic       clk;
  logic       resetn;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       busy;
  logic       done;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;

  alien_sprite_drawer #(
    .SPRITE_W     (SW),
    .SPRITE_H     (SH),
    .ALIEN_COLOUR (ALIEN),
    .BG_COLOUR    (BG),
    .SCREEN_W     (SCR_W),
    .SCREEN_H     (SCR_H)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .busy   (busy),
    .done   (done),
    .plot   (plot),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .colour (colour)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // Entry layout: {chk_pix, busy, done, plot, x[7:0], y[6:0], colour[2:0]}
  logic [21:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_busy = 0;
  int          n_plot = 0;
  logic        m_valid;
  logic [7:0]  m_old_x;
  logic [6:0]  m_old_y;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] pk(input logic chk, input logic b,
                                     input logic d, input logic p,
                                     input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] c);
    return {chk, b, d, p, x, y, c};
  endfunction

  function automatic logic rom_at(input int r, input int c);
`ifdef SPRITE_ROM_EN
    logic [7:0] row;
    row = ROM_TB[r];
    return row[c];
`else
    return (r >= 0) && (c >= 0);
`endif
  endfunction

  // Every cycle of one complete redraw to (nx, ny), starting from whatever
  // the model believes is currently on screen.
  task automatic build_redraw(input logic [7:0] nx, input logic [6:0] ny);
    int   sx, sy;
    logic vis;
    if (m_valid) begin
      for (int r = 0; r < SH; r++) begin
        for (int c = 0; c < SW; c++) begin
          sx  = int'(m_old_x) + c;
          sy  = int'(m_old_y) + r;
          vis = (sx < SCR_W) && (sy < SCR_H);
          exp_q.push_back(pk(1'b1, 1'b1, 1'b0, vis, 8'(sx), 7'(sy), BG));
        end
      end
    end
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        sx  = int'(nx) + c;
        sy  = int'(ny) + r;
        vis = (sx < SCR_W) && (sy < SCR_H) && rom_at(r, c);
        exp_q.push_back(pk(1'b1, 1'b1, 1'b0, vis, 8'(sx), 7'(sy), ALIEN));
      end
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 7'd0, 3'd0));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
    m_old_x = nx;
    m_old_y = ny;
    m_valid = 1'b1;
  endtask

  // One clock: sample inputs as the DUT sees them at the rising edge, then
  // compare outputs at the falling edge.
  task automatic step();
    logic [7:0]  px_e;
    logic [6:0]  py_e;
    logic        rst_e;
    logic [21:0] e;
    @(posedge clk);
    px_e  = pos_x;
    py_e  = pos_y;
    rst_e = resetn;
    @(negedge clk);
    if (!rst_e) begin
      exp_q.delete();
      m_valid = 1'b0;
      check_val("rst_plot",   plot,   0);
      check_val("rst_busy",   busy,   0);
      check_val("rst_done",   done,   0);
      check_val("rst_vga_x",  vga_x,  0);
      check_val("rst_vga_y",  vga_y,  0);
      check_val("rst_colour", colour, BG);
    end else begin
      if (exp_q.size() == 0) begin
        if (!m_valid || px_e != m_old_x || py_e != m_old_y)
          build_redraw(px_e, py_e);
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      check_val("busy", busy, e[20]);
      check_val("done", done, e[19]);
      check_val("plot", plot, e[18]);
      if (e[21]) begin
        check_val("vga_x",  vga_x,  e[17:10]);
        check_val("vga_y",  vga_y,  e[9:3]);
        check_val("colour", colour, e[2:0]);
      end
    end
    if (busy) n_busy++;
    if (plot) n_plot++;
  endtask

  // Run until the model has no outstanding redraw, with a cycle budget.
  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (exp_q.size() != 0 && k < budget);
    if (exp_q.size() != 0) check_val("idle_timeout", 1, 0);
  endtask

  task automatic set_pos(input logic [7:0] x, input logic [6:0] y);
    pos_x = x;
    pos_y = y;
  endtask

  // Drops reset mid-operation and checks the asynchronous clear.
  task automatic pulse_reset(input logic [7:0] x, input logic [6:0] y);
    resetn = 1'b0;
    #1;
    check_val("async_plot", plot, 0);
    check_val("async_busy", busy, 0);
    set_pos(x, y);
    step();
    resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn  = 1'b0;
    m_valid = 1'b0;
    m_old_x = 8'd0;
    m_old_y = 7'd0;
    set_pos(8'd82, 7'd15);
    repeat (3) step();
    resetn = 1'b1;

    // First draw: no erase, 16 pixels then done.
    n_busy = 0; n_plot = 0;
    wait_idle(200);
    check_val("first_busy_cycles", n_busy, SW * SH + 1);
`ifndef SPRITE_ROM_EN
    check_val("first_plot_count", n_plot, 16);
`endif

    // One-pixel move: erase + draw + done.
    set_pos(8'd83, 7'd15);
    n_busy = 0; n_plot = 0;
    wait_idle(200);
    check_val("move_busy_cycles", n_busy, 2 * SW * SH + 1);
`ifndef SPRITE_ROM_EN
    check_val("move_plot_count", n_plot, 32);
`endif

    // Position held: nothing happens.
    n_busy = 0; n_plot = 0;
    repeat (100) step();
    check_val("hold_busy_cycles", n_busy, 0);
    check_val("hold_plot_count", n_plot, 0);

    // Corner clip: full erase, 6 visible draw pixels.
    set_pos(8'd158, 7'd117);
    n_busy = 0; n_plot = 0;
    wait_idle(200);
    check_val("clip_busy_cycles", n_busy, 2 * SW * SH + 1);
`ifndef SPRITE_ROM_EN
    check_val("clip_plot_count", n_plot, 16 + 6);
`endif

    // Moves while busy: 83 -> 84 completes, then 84 -> 85.
    set_pos(8'd83, 7'd15);
    wait_idle(200);
    set_pos(8'd84, 7'd15);
    n_busy = 0;
    repeat (3) step();
    set_pos(8'd85, 7'd15);
    wait_idle(200);
    wait_idle(200);
    check_val("busy_skip_cycles", n_busy, 2 * (2 * SW * SH + 1));

    // Reset mid-DRAW, then a fresh draw with no erase.
    set_pos(8'd86, 7'd15);
    repeat (20) step();
    pulse_reset(8'd90, 7'd19);
    n_busy = 0;
    wait_idle(200);
    check_val("post_reset_busy", n_busy, SW * SH + 1);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int r;
      set_pos(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
      r = $urandom_range(0, 9);
      if (r < 6) begin
        wait_idle(200);
      end else if (r < 9) begin
        repeat ($urandom_range(1, 30)) step();
        set_pos(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
        wait_idle(200);
      end else begin
        repeat ($urandom_range(1, 30)) step();
        pulse_reset(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)));
        wait_idle(200);
      end
    end
    wait_idle(200);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
